apb_req_arbiter: RTL and testbench

APB_REQ_ARBITER -- requirements
Module: apb_req_arbiter

---
 rtl/apb_req_arbiter.sv | 145 ++++++++++++++
 tb/tb_apb_req_arbiter.sv | 334 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/apb_req_arbiter.sv
// Two-requester round-robin arbiter driving a single APB master port.
// One transfer in flight; back-to-back hand-over to the other requester from ACCESS.
module apb_req_arbiter #(
  parameter int unsigned ADDR_W = 16,
  parameter int unsigned DATA_W = 32
) (
  input  logic              pclk,
  input  logic              rst_n,
  input  logic [1:0]        req,
  input  logic [1:0]        we,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata0,
  input  logic [DATA_W-1:0] wdata1,
  output logic [1:0]        gnt,
  output logic [1:0]        done,
  output logic [DATA_W-1:0] rdata,
  output logic              psel,
  output logic              penable,
  output logic              pwrite,
  output logic [ADDR_W-1:0] paddr,
  output logic [DATA_W-1:0] pwdata,
  input  logic [DATA_W-1:0] prdata
);

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    ACCESS
  } state_e;

  state_e            state_q, state_d;
  logic              last_q, last_d;
  logic              cur_q, cur_d;
  logic              pwrite_q, pwrite_d;
  logic [ADDR_W-1:0] paddr_q, paddr_d;
  logic [DATA_W-1:0] pwdata_q, pwdata_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic [1:0]        done_q, done_d;

  logic              grant_vld;
  logic              grant_idx;

  // Grant decision: from IDLE round-robin; from ACCESS only the other requester.
  always_comb begin
    grant_vld = 1'b0;
    grant_idx = 1'b0;
    case (state_q)
      IDLE: begin
        if (req != 2'b00) begin
          grant_vld = 1'b1;
          grant_idx = (req == 2'b11) ? ~last_q : req[1];
        end
      end
      ACCESS: begin
        if (req[~cur_q]) begin
          grant_vld = 1'b1;
          grant_idx = ~cur_q;
        end
      end
      default: ;
    endcase
    if (!rst_n) begin
      grant_vld = 1'b0;
    end
  end

  always_ff @(posedge pclk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (grant_vld) state_d = SETUP;
      SETUP:   state_d = ACCESS;
      ACCESS:  state_d = grant_vld ? SETUP : IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    psel    = (state_q == SETUP) || (state_q == ACCESS);
    penable = (state_q == ACCESS);
    gnt     = '0;
    if (grant_vld) begin
      gnt = grant_idx ? 2'b10 : 2'b01;
    end
  end

  always_comb begin
    last_d   = last_q;
    cur_d    = cur_q;
    pwrite_d = pwrite_q;
    paddr_d  = paddr_q;
    pwdata_d = pwdata_q;
    rdata_d  = rdata_q;
    done_d   = '0;
    if (grant_vld) begin
      last_d   = grant_idx;
      cur_d    = grant_idx;
      pwrite_d = we[grant_idx];
      paddr_d  = grant_idx ? addr1 : addr0;
      pwdata_d = grant_idx ? wdata1 : wdata0;
    end
    if (state_q == ACCESS) begin
      done_d = cur_q ? 2'b10 : 2'b01;
      if (!pwrite_q) begin
        rdata_d = prdata;
      end
    end
  end

  // last_q resets to 1 so that requester 0 wins the first contended grant.
  always_ff @(posedge pclk or negedge rst_n) begin
    if (!rst_n) begin
      last_q   <= 1'b1;
      cur_q    <= 1'b0;
      pwrite_q <= 1'b0;
      paddr_q  <= '0;
      pwdata_q <= '0;
      rdata_q  <= '0;
      done_q   <= '0;
    end else begin
      last_q   <= last_d;
      cur_q    <= cur_d;
      pwrite_q <= pwrite_d;
      paddr_q  <= paddr_d;
      pwdata_q <= pwdata_d;
      rdata_q  <= rdata_d;
      done_q   <= done_d;
    end
  end

  assign pwrite = pwrite_q;
  assign paddr  = paddr_q;
  assign pwdata = pwdata_q;
  assign rdata  = rdata_q;
  assign done   = done_q;

endmodule

// File: tb/tb_apb_req_arbiter.sv
// Bench for apb_req_arbiter: vector table feeding a done-time scoreboard,
// an APB protocol monitor, and hand sequences for fairness and mid-transfer reset.
module tb_apb_req_arbiter;

  localparam int unsigned ADDR_W = 16;
  localparam int unsigned DATA_W = 32;

  logic              pclk;
  logic              rst_n;
  logic [1:0]        req;
  logic [1:0]        we;
  logic [ADDR_W-1:0] addr0;
  logic [ADDR_W-1:0] addr1;
  logic [DATA_W-1:0] wdata0;
  logic [DATA_W-1:0] wdata1;
  logic [1:0]        gnt;
  logic [1:0]        done;
  logic [DATA_W-1:0] rdata;
  logic              psel;
  logic              penable;
  logic              pwrite;
  logic [ADDR_W-1:0] paddr;
  logic [DATA_W-1:0] pwdata;
  logic [DATA_W-1:0] prdata;

  logic [DATA_W-1:0] mem [0:255];

  apb_req_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .pclk    (pclk),
    .rst_n   (rst_n),
    .req     (req),
    .we      (we),
    .addr0   (addr0),
    .addr1   (addr1),
    .wdata0  (wdata0),
    .wdata1  (wdata1),
    .gnt     (gnt),
    .done    (done),
    .rdata   (rdata),
    .psel    (psel),
    .penable (penable),
    .pwrite  (pwrite),
    .paddr   (paddr),
    .pwdata  (pwdata),
    .prdata  (prdata)
  );

  initial pclk = 1'b0;
  always #5 pclk = ~pclk;

  // Zero-wait-state slave backed by a small memory.
  assign prdata = (psel && penable && !pwrite) ? mem[paddr[7:0]] : '0;
  always @(posedge pclk) begin
    if (psel && penable && pwrite) mem[paddr[7:0]] = pwdata;
  end

  typedef struct {
    logic              who;
    logic              write;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic [DATA_W-1:0] rdata;
    int unsigned       gap;
  } exp_t;

  typedef struct {
    logic [1:0]        req;
    logic [1:0]        we;
    logic [ADDR_W-1:0] a0;
    logic [ADDR_W-1:0] a1;
    logic [DATA_W-1:0] wd0;
    logic [DATA_W-1:0] wd1;
    logic              first;
    logic [DATA_W-1:0] rd0;
    logic [DATA_W-1:0] rd1;
  } vec_t;

  exp_t exp_q[$];
  vec_t vt[11];

  int          n_vec = 0;
  int          n_err = 0;
  int unsigned cyc = 0;
  int unsigned last_done_cyc = 0;

  logic              prev_setup = 1'b0;
  logic [ADDR_W-1:0] sv_addr;
  logic              sv_write;
  logic [DATA_W-1:0] sv_wdata;
  logic [ADDR_W-1:0] acc_addr = '0;
  logic              acc_write = 1'b0;
  logic [DATA_W-1:0] acc_wdata = '0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] expv);
    n_vec++;
    if (act !== expv) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, required 0x%0h (t=%0t)", name, act, expv, $time);
    end
  endtask

  // Protocol monitor and scoreboard consumer, sampled mid-cycle.
  always @(negedge pclk) begin
    exp_t e;
    if (!rst_n) begin
      prev_setup = 1'b0;
    end else begin
      cyc++;
      check("gnt_onehot0", 64'($onehot0(gnt)), 64'd1);
      if (penable) check("penable_needs_psel", 64'(psel), 64'd1);
      if (prev_setup) begin
        check("setup_then_access", 64'({psel, penable}), 64'd3);
        check("paddr_stable", 64'(paddr), 64'(sv_addr));
        check("pwrite_stable", 64'(pwrite), 64'(sv_write));
        check("pwdata_stable", 64'(pwdata), 64'(sv_wdata));
      end
      prev_setup = psel && !penable;
      sv_addr    = paddr;
      sv_write   = pwrite;
      sv_wdata   = pwdata;
      if (psel && penable) begin
        acc_addr  = paddr;
        acc_write = pwrite;
        acc_wdata = pwdata;
      end
      if (done != 2'b00) begin
        if (exp_q.size() == 0) begin
          check("unexpected_done", 64'(done), 64'd0);
        end else begin
          e = exp_q.pop_front();
          check("done", 64'(done), e.who ? 64'd2 : 64'd1);
          check("xfer_addr", 64'(acc_addr), 64'(e.addr));
          check("xfer_write", 64'(acc_write), 64'(e.write));
          if (e.write) check("xfer_wdata", 64'(acc_wdata), 64'(e.wdata));
          check("rdata", 64'(rdata), 64'(e.rdata));
          if (e.gap != 0) check("done_gap", 64'(cyc - last_done_cyc), 64'(e.gap));
        end
        last_done_cyc = cyc;
      end
    end
  end

  task automatic drain();
    int unsigned n;
    n = 0;
    while (exp_q.size() != 0 && n < 20) begin
      @(posedge pclk);
      n++;
    end
    check("drain_timeout", 64'(exp_q.size()), 64'd0);
    exp_q.delete();
    @(posedge pclk);
    #1;
  endtask

  task automatic apply(input vec_t v);
    exp_t        e;
    logic [1:0]  g;
    logic        w;
    int unsigned n;
    we     = v.we;
    addr0  = v.a0;
    addr1  = v.a1;
    wdata0 = v.wd0;
    wdata1 = v.wd1;
    for (int k = 0; k < 2; k++) begin
      if (k == 0 || v.req == 2'b11) begin
        w       = (k == 0) ? v.first : ~v.first;
        e.who   = w;
        e.write = v.we[w];
        e.addr  = w ? v.a1 : v.a0;
        e.wdata = w ? v.wd1 : v.wd0;
        e.rdata = w ? v.rd1 : v.rd0;
        e.gap   = (k == 1) ? 2 : 0;
        exp_q.push_back(e);
      end
    end
    req = v.req;
    n = 0;
    // Each requester drops its request on the edge after it sees gnt.
    while (req != 2'b00 && n < 16) begin
      @(negedge pclk);
      g = gnt;
      @(posedge pclk);
      #1;
      req = req & ~g;
      n++;
    end
    check("grant_timeout", 64'(req), 64'd0);
    req = 2'b00;
    drain();
  endtask

  initial begin
    exp_t        e;
    logic [1:0]  g;
    int unsigned n;
    int unsigned ngr;
    int unsigned cnt0;
    int unsigned cnt1;

    for (int i = 0; i < 256; i++) mem[i] = '0;
    mem[8'h00] = 32'h0176_5A03;
    mem[8'h10] = 32'h1234_0110;
    mem[8'h20] = 32'hCAFE_0120;

    vt[0]  = '{2'b11, 2'b10, 16'h0110, 16'h0114, 32'h0,         32'h5,         1'b0, 32'h1234_0110, 32'h1234_0110};
    vt[1]  = '{2'b01, 2'b00, 16'h0100, 16'h0000, 32'h0,         32'h0,         1'b0, 32'h0176_5A03, 32'h0};
    vt[2]  = '{2'b01, 2'b01, 16'h0104, 16'h0000, 32'hDEAD_BEEF, 32'h0,         1'b0, 32'h0176_5A03, 32'h0};
    vt[3]  = '{2'b01, 2'b00, 16'h0104, 16'h0000, 32'h0,         32'h0,         1'b0, 32'hDEAD_BEEF, 32'h0};
    vt[4]  = '{2'b10, 2'b00, 16'h0000, 16'h0114, 32'h0,         32'h0,         1'b1, 32'h0,         32'h5};
    vt[5]  = '{2'b11, 2'b11, 16'h0130, 16'h0134, 32'hA5A5_0001, 32'h5A5A_0002, 1'b0, 32'h5,         32'h5};
    vt[6]  = '{2'b11, 2'b00, 16'h0134, 16'h0130, 32'h0,         32'h0,         1'b0, 32'h5A5A_0002, 32'hA5A5_0001};
    vt[7]  = '{2'b10, 2'b10, 16'h0000, 16'h0140, 32'h0,         32'h0000_00FF, 1'b1, 32'h0,         32'hA5A5_0001};
    vt[8]  = '{2'b11, 2'b00, 16'h0140, 16'h0100, 32'h0,         32'h0,         1'b0, 32'h0000_00FF, 32'h0176_5A03};
    vt[9]  = '{2'b01, 2'b00, 16'h0110, 16'h0000, 32'h0,         32'h0,         1'b0, 32'h1234_0110, 32'h0};
    vt[10] = '{2'b11, 2'b00, 16'h0100, 16'h0104, 32'h0,         32'h0,         1'b1, 32'h0176_5A03, 32'hDEAD_BEEF};

    rst_n  = 1'b0;
    req    = 2'b11;
    we     = 2'b00;
    addr0  = '0;
    addr1  = '0;
    wdata0 = '0;
    wdata1 = '0;
    repeat (2) @(posedge pclk);
    @(negedge pclk);
    check("rst_psel", 64'(psel), 64'd0);
    check("rst_penable", 64'(penable), 64'd0);
    check("rst_pwrite", 64'(pwrite), 64'd0);
    check("rst_paddr", 64'(paddr), 64'd0);
    check("rst_pwdata", 64'(pwdata), 64'd0);
    check("rst_rdata", 64'(rdata), 64'd0);
    check("rst_gnt", 64'(gnt), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    req = 2'b00;
    @(posedge pclk);
    #1;
    rst_n = 1'b1;
    @(posedge pclk);
    #1;

    for (int i = 0; i < 11; i++) apply(vt[i]);

    // Fairness: both requests held; requester 0 was served last, so 1 leads.
    we     = 2'b11;
    addr0  = 16'h0150;
    addr1  = 16'h0154;
    wdata0 = 32'h0000_0011;
    wdata1 = 32'h0000_0022;
    for (int k = 0; k < 8; k++) begin
      e.who   = (k % 2 == 0) ? 1'b1 : 1'b0;
      e.write = 1'b1;
      e.addr  = e.who ? 16'h0154 : 16'h0150;
      e.wdata = e.who ? 32'h0000_0022 : 32'h0000_0011;
      e.rdata = 32'h0176_5A03;
      e.gap   = (k == 0) ? 0 : 2;
      exp_q.push_back(e);
    end
    req  = 2'b11;
    ngr  = 0;
    cnt0 = 0;
    cnt1 = 0;
    n    = 0;
    while (ngr < 8 && n < 40) begin
      @(negedge pclk);
      g = gnt;
      if (g != 2'b00) begin
        check("fair_gnt", 64'(g), (ngr % 2 == 0) ? 64'd2 : 64'd1);
        if (g[1]) cnt1++;
        else cnt0++;
        ngr++;
      end
      @(posedge pclk);
      #1;
      n++;
    end
    req = 2'b00;
    check("fair_count0", 64'(cnt0), 64'd4);
    check("fair_count1", 64'(cnt1), 64'd4);
    drain();

    // Reset during ACCESS of a read, with the request still pending.
    we    = 2'b00;
    addr0 = 16'h0120;
    req   = 2'b01;
    n     = 0;
    @(negedge pclk);
    while (!(psel && penable) && n < 10) begin
      @(negedge pclk);
      n++;
    end
    check("rst_reach_access", 64'(psel && penable), 64'd1);
    check("no_self_regrant", 64'(gnt), 64'd0);
    #1;
    rst_n = 1'b0;
    #1;
    check("abort_psel", 64'(psel), 64'd0);
    check("abort_penable", 64'(penable), 64'd0);
    check("abort_rdata", 64'(rdata), 64'd0);
    check("abort_gnt", 64'(gnt), 64'd0);
    repeat (2) begin
      @(negedge pclk);
      check("abort_no_done", 64'(done), 64'd0);
      check("abort_rdata_hold", 64'(rdata), 64'd0);
    end
    #1;
    e.who   = 1'b0;
    e.write = 1'b0;
    e.addr  = 16'h0120;
    e.wdata = '0;
    e.rdata = 32'hCAFE_0120;
    e.gap   = 0;
    exp_q.push_back(e);
    rst_n = 1'b1;
    #1;
    check("regrant_after_reset", 64'(gnt), 64'd1);
    @(posedge pclk);
    #1;
    req = 2'b00;
    drain();
    repeat (3) @(posedge pclk);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, got timeout, required finish");
    $fatal(1, "watchdog expired");
  end

endmodule
